regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREG, default 16, SHALL set the number of register32 instances driven; one LE bit per register.
REQ-002 Parameter AW, default 4, SHALL set the register address width; NREG SHALL equal 2**AW.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Clr  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ReqA  input  1  SHALL be the ALU writeback write request.
REQ-006 AddrA  input  AW  SHALL be the ALU writeback destination register.
REQ-007 DataA  input  32  SHALL be the ALU writeback data.
REQ-008 ReqB  input  1  SHALL be the load writeback write request.
REQ-009 AddrB  input  AW  SHALL be the load writeback destination register.
REQ-010 DataB  input  32  SHALL be the load writeback data.
REQ-011 GntA  output  1  SHALL pulse high for the cycle in which port A's write is applied.
REQ-012 GntB  output  1  SHALL pulse high for the cycle in which port B's write is applied.
REQ-013 LE  output  NREG  SHALL be one-hot (or all-zero) load enables to the register32 array.
REQ-014 WD  output  32  SHALL be the shared D bus to all register32 instances.
REQ-015 Busy  output  1  SHALL be high when any request is pending and not granted this cycle.

Function
REQ-016 FSM states: IDLE, WR_A, WR_B; state, GntA/GntB, LE, WD SHALL be registered.
REQ-017 A request SHALL be eligible at an edge if Req is high and that port's Gnt is not high in the current cycle.
REQ-018 Exactly one eligible port: next state WR_A/WR_B; WD latched from its Data; LE bit Addr set.
REQ-019 Both eligible: winner SHALL be the port not granted most recently (round-robin pointer Last).
REQ-020 Last SHALL update only on a grant, to the granted port.
REQ-021 No eligible port: next state IDLE, LE all-zero, Gnt low, WD holds its previous value.
REQ-022 Latency: request sampled at edge N -> Gnt/LE/WD valid during cycle N+1 -> register32 loads at edge N+1.
REQ-023 Requester SHALL hold Req/Addr/Data stable until it sees Gnt; it may drop Req or present a new request in the Gnt cycle.
REQ-024 Same-port back-to-back: a continuously held Req SHALL be granted at most every other cycle.
REQ-025 Both ports continuously requesting SHALL alternate A,B,A,B with one write per cycle.
REQ-026 Both ports targeting the same address: both writes SHALL occur in grant order; last granted value persists.
REQ-027 Busy SHALL be combinational: (ReqA and not GntA) or (ReqB and not GntB).

Reset
REQ-028 Clr low SHALL immediately force state IDLE, GntA=0, GntB=0, LE=0, WD=32'h00000000, Last=B.
REQ-029 Clr asserted mid-grant SHALL drop LE asynchronously; the interrupted write is lost, not replayed.
REQ-030 First edge with Clr high SHALL arbitrate normally; A wins a simultaneous first request.

Structure
REQ-031 Package regfile_pkg SHALL hold the FSM state enumeration, NREG/AW defaults, and port-ID constants.
REQ-032 Sub-module decoder_le SHALL convert address plus enable into the one-hot NREG-bit LE vector.

Verification
REQ-033 Reset: Clr=0 with ReqA=1 -> LE=0, GntA=0, WD=0 throughout; after Clr=1, first grant goes to A.
REQ-034 Single write: ReqA, AddrA=3, DataA=32'h0000_00A5 -> next cycle GntA=1, LE=16'h0008, WD=32'h0000_00A5.
REQ-035 Contention: ReqA AddrA=1 DataA=1, ReqB AddrB=2 DataB=2, held -> GntA cycle 1 (LE=16'h0002), GntB cycle 2 (LE=16'h0004).
REQ-036 Same address: A=(5,32'h11), B=(5,32'h22), Last=A -> B first, then A; register 5 ends 32'h11.
REQ-037 Sustained: both held 8 cycles with new data after each Gnt -> strict alternation, 8 writes, no cycle LE zero.
REQ-038 Mid-grant reset: Clr=0 during GntB cycle -> LE, GntB drop same cycle; B must re-request after release.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the register-file write arbiter:
//     - default register count / address width
//     - arbiter FSM state enumeration
//     - port identifiers used by the round-robin pointer
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned NREG_DEF = 16;
    localparam int unsigned AW_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/regfile_write_arbiter_decoder_le.sv
// ---------------------------------------------------------------------------
// decoder_le
//   Converts a register address plus an enable into a one-hot load-enable
//   vector for the register32 array. All-zero when en is low.
//   Ports:
//     en   - write enable
//     addr - destination register index (AW bits)
//     le   - one-hot load enables (NREG bits)
// ---------------------------------------------------------------------------
module decoder_le
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] le
);

    always_comb begin
        le = '0;
        if (en) begin
            le[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Arbitrates two writeback sources (A: ALU, B: load) onto a shared
//   register32 array. One write per cycle; Gnt, LE and WD are registered and
//   valid the cycle after the request is sampled. Contention is resolved
//   round-robin: the port not granted most recently wins.
//   Ports:
//     Clk          - clock, rising edge
//     Clr          - asynchronous active-low reset
//     ReqA/AddrA/DataA - ALU writeback request, destination, data
//     ReqB/AddrB/DataB - load writeback request, destination, data
//     GntA/GntB    - one-cycle grant pulse during the applied write
//     LE           - one-hot (or zero) load enables to register32 array
//     WD           - shared write data bus
//     Busy         - a request is pending and not granted this cycle
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            ReqA,
    input  logic [AW-1:0]   AddrA,
    input  logic [31:0]     DataA,
    input  logic            ReqB,
    input  logic [AW-1:0]   AddrB,
    input  logic [31:0]     DataB,
    output logic            GntA,
    output logic            GntB,
    output logic [NREG-1:0] LE,
    output logic [31:0]     WD,
    output logic            Busy
);

    state_t          state_q, state_d;
    port_t           last_q, last_d;
    logic            gnt_a_d, gnt_b_d;
    logic [31:0]     wd_d;
    logic [NREG-1:0] le_d;
    logic [AW-1:0]   sel_addr;
    logic            grant_en;
    logic            elig_a, elig_b;

    // A port being granted this cycle is not eligible again at the next
    // edge, which yields the every-other-cycle limit and A/B alternation.
    assign elig_a = ReqA && !GntA;
    assign elig_b = ReqB && !GntB;

    assign Busy = (ReqA && !GntA) || (ReqB && !GntB);

    always_comb begin
        state_d  = IDLE;
        last_d   = last_q;
        wd_d     = WD;
        sel_addr = AddrA;
        grant_en = 1'b0;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;

        if (elig_a && (!elig_b || last_q == PORT_B)) begin
            state_d  = WR_A;
            last_d   = PORT_A;
            wd_d     = DataA;
            sel_addr = AddrA;
            grant_en = 1'b1;
            gnt_a_d  = 1'b1;
        end else if (elig_b) begin
            state_d  = WR_B;
            last_d   = PORT_B;
            wd_d     = DataB;
            sel_addr = AddrB;
            grant_en = 1'b1;
            gnt_b_d  = 1'b1;
        end
    end

    decoder_le #(
        .NREG (NREG),
        .AW   (AW)
    ) u_decoder_le (
        .en   (grant_en),
        .addr (sel_addr),
        .le   (le_d)
    );

    // Last resets to B so that A wins a simultaneous first request.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
            last_q  <= PORT_B;
            GntA    <= 1'b0;
            GntB    <= 1'b0;
            LE      <= '0;
            WD      <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            GntA    <= gnt_a_d;
            GntB    <= gnt_b_d;
            LE      <= le_d;
            WD      <= wd_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        ReqA, ReqB;
    logic [3:0]  AddrA, AddrB;
    logic [31:0] DataA, DataB;
    logic        GntA, GntB, Busy;
    logic [15:0] LE;
    logic [31:0] WD;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(
        .NREG (16),
        .AW   (4)
    ) dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .ReqA  (ReqA),
        .AddrA (AddrA),
        .DataA (DataA),
        .ReqB  (ReqB),
        .AddrB (AddrB),
        .DataB (DataB),
        .GntA  (GntA),
        .GntB  (GntB),
        .LE    (LE),
        .WD    (WD),
        .Busy  (Busy)
    );

    always #5 Clk = ~Clk;

    // Downstream register32 array (not reset by Clr).
    logic [31:0] regs [16] = '{default: '0};
    int          wr12 = 0;
    always @(posedge Clk) begin
        for (int i = 0; i < 16; i++) begin
            if (LE[i]) regs[i] <= WD;
        end
        if (LE[12]) wr12 <= wr12 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ra;
        logic [3:0]  aa;
        logic [31:0] da;
        logic        rb;
        logic [3:0]  ab;
        logic [31:0] db;
        logic        busy;
        logic        ga;
        logic        gb;
        logic [15:0] le;
        logic [31:0] wd;
    } vec_t;

    vec_t vec [12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ra aa  da            rb ab  db            busy ga gb le        wd
        vec[0]  = '{1, 1, 32'h1,        1, 2, 32'h2,        1, 1, 0, 16'h0002, 32'h1};
        vec[1]  = '{0, 0, 32'h0,        1, 2, 32'h2,        1, 0, 1, 16'h0004, 32'h2};
        vec[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 16'h0000, 32'h2};
        vec[3]  = '{1, 3, 32'hA5,       0, 0, 32'h0,        1, 1, 0, 16'h0008, 32'hA5};
        vec[4]  = '{1, 7, 32'h77,       0, 0, 32'h0,        0, 0, 0, 16'h0000, 32'hA5};
        vec[5]  = '{1, 7, 32'h77,       0, 0, 32'h0,        1, 1, 0, 16'h0080, 32'h77};
        vec[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 16'h0000, 32'h77};
        vec[7]  = '{0, 0, 32'h0,        1, 15, 32'hDEADBEEF, 1, 0, 1, 16'h8000, 32'hDEADBEEF};
        vec[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 16'h0000, 32'hDEADBEEF};
        vec[9]  = '{1, 4, 32'h44,       1, 6, 32'h66,       1, 1, 0, 16'h0010, 32'h44};
        vec[10] = '{0, 0, 32'h0,        1, 6, 32'h66,       1, 0, 1, 16'h0040, 32'h66};
        vec[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 16'h0000, 32'h66};

        // Reset held with a pending request: outputs stay cleared.
        Clr = 1'b0;
        ReqA = 1'b1; AddrA = 4'd3; DataA = 32'h5;
        ReqB = 1'b0; AddrB = 4'd0; DataB = 32'h0;
        repeat (3) begin
            @(posedge Clk); #1;
            chk("rst_le",   {16'h0, LE}, 32'h0);
            chk("rst_gnta", {31'h0, GntA}, 32'h0);
            chk("rst_wd",   WD, 32'h0);
        end
        Clr = 1'b1;

        // Directed table; first entry is the first arbitration after reset.
        for (int i = 0; i < 12; i++) begin
            ReqA = vec[i].ra; AddrA = vec[i].aa; DataA = vec[i].da;
            ReqB = vec[i].rb; AddrB = vec[i].ab; DataB = vec[i].db;
            #1;
            chk($sformatf("v%0d_busy", i), {31'h0, Busy}, {31'h0, vec[i].busy});
            @(posedge Clk); #1;
            chk($sformatf("v%0d_gnta", i), {31'h0, GntA}, {31'h0, vec[i].ga});
            chk($sformatf("v%0d_gntb", i), {31'h0, GntB}, {31'h0, vec[i].gb});
            chk($sformatf("v%0d_le", i),   {16'h0, LE},   {16'h0, vec[i].le});
            chk($sformatf("v%0d_wd", i),   WD,            vec[i].wd);
        end

        // Same address: make A most recent, then both target register 5.
        ReqA = 1'b1; AddrA = 4'd0; DataA = 32'h1; ReqB = 1'b0;
        @(posedge Clk); #1;
        chk("sa_pre_gnta", {31'h0, GntA}, 32'h1);
        AddrA = 4'd5; DataA = 32'h11;
        ReqB = 1'b1; AddrB = 4'd5; DataB = 32'h22;
        #1;
        chk("sa_busy", {31'h0, Busy}, 32'h1);
        @(posedge Clk); #1;
        chk("sa_first_gntb", {31'h0, GntB}, 32'h1);
        chk("sa_first_le",   {16'h0, LE}, 32'h0020);
        chk("sa_first_wd",   WD, 32'h22);
        ReqB = 1'b0;
        @(posedge Clk); #1;
        chk("sa_second_gnta", {31'h0, GntA}, 32'h1);
        chk("sa_second_le",   {16'h0, LE}, 32'h0020);
        chk("sa_second_wd",   WD, 32'h11);
        ReqA = 1'b0;
        @(posedge Clk); #1;
        chk("sa_reg5", regs[5], 32'h11);

        // Sustained contention: Last=A, so B leads, then strict alternation.
        begin
            logic [31:0] da, db;
            logic        exp_b;
            da = 32'h100; db = 32'h200;
            ReqA = 1'b1; AddrA = 4'd8; DataA = da;
            ReqB = 1'b1; AddrB = 4'd9; DataB = db;
            for (int k = 0; k < 8; k++) begin
                exp_b = (k % 2 == 0);
                @(posedge Clk); #1;
                chk($sformatf("sus%0d_gnta", k), {31'h0, GntA}, {31'h0, !exp_b});
                chk($sformatf("sus%0d_gntb", k), {31'h0, GntB}, {31'h0, exp_b});
                chk($sformatf("sus%0d_le", k), {16'h0, LE}, exp_b ? 32'h0200 : 32'h0100);
                chk($sformatf("sus%0d_wd", k), WD, exp_b ? db : da);
                if (exp_b) begin db = db + 1; DataB = db; end
                else       begin da = da + 1; DataA = da; end
                #1;
                chk($sformatf("sus%0d_busy", k), {31'h0, Busy}, 32'h1);
            end
            ReqA = 1'b0; ReqB = 1'b0;
            @(posedge Clk); #1;
            chk("sus_reg8", regs[8], 32'h103);
            chk("sus_reg9", regs[9], 32'h203);
        end

        // Reset during a B grant: LE/GntB drop at once, write is lost.
        ReqB = 1'b1; AddrB = 4'd12; DataB = 32'hCAFE;
        @(posedge Clk); #1;
        chk("mr_gntb", {31'h0, GntB}, 32'h1);
        #2;
        Clr = 1'b0;
        #1;
        chk("mr_le_drop",   {16'h0, LE}, 32'h0);
        chk("mr_gntb_drop", {31'h0, GntB}, 32'h0);
        @(posedge Clk); #1;
        Clr = 1'b1;
        chk("mr_lost", wr12, 0);
        @(posedge Clk); #1;
        chk("mr_regrant_gntb", {31'h0, GntB}, 32'h1);
        chk("mr_regrant_le",   {16'h0, LE}, 32'h1000);
        chk("mr_regrant_wd",   WD, 32'hCAFE);
        ReqB = 1'b0;
        @(posedge Clk); #1;
        chk("mr_reg12", regs[12], 32'hCAFE);
        chk("mr_wr12",  wr12, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
